serial_sub_w_regs: RTL and testbench
====================================

# serial_sub_w_regs

Bit-serial registered ripple-borrow subtractor, the inverse-operation counterpart to the team's registered ripple-carry adder. It accepts two `width`-bit unsigned operands on a `start` pulse and computes one difference bit per clock, LSB first. It then presents a registered `width+1`-bit result, `{borrow, difference}`, with a one-cycle `done` strobe. It serves datapaths that trade latency for area: one full-subtractor cell plus shift registers, instead of a `width`-stage borrow chain.

## Interface
- `width`, default 4: operand width in bits; legal range ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous reset, active-high.
- `start`, in, 1: request a subtraction; sampled only in IDLE.
- `data_ina`, in, `width`: minuend A, unsigned; sampled with an accepted `start`.
- `data_inb`, in, `width`: subtrahend B, unsigned; sampled with an accepted `start`.
- `busy`, out, 1: high while an operation is in progress (state RUN).
- `done`, out, 1: one-cycle strobe; `data_out` was updated on the same edge.
- `data_out`, out, `width+1`: registered result `{borrow, (A−B) mod 2^width}`. It equals the `width+1`-bit two's complement of A−B with both operands zero-extended.

## Operation
- Internal state:
  - `a_sh`, `b_sh`: `width`-bit shift registers.
  - `res_sh`: `width`-bit result shift register.
  - `bw`: borrow flop.
  - `cnt`: bit counter, `$clog2(width+1)` bits.
  - FSM state: IDLE, RUN.
- IDLE:
  - `busy`=0.
  - On an edge with `start`=1: load `a_sh`←`data_ina` and `b_sh`←`data_inb`; clear `bw`, `cnt`, `res_sh`; go to RUN.
  - With `start`=0: no change.
- RUN, on each edge:
  - Take bits `a0`=`a_sh[0]`, `b0`=`b_sh[0]`.
  - `d` = `a0` ^ `b0` ^ `bw`.
  - `bw` ← (~`a0` & `b0`) | (~(`a0` ^ `b0`) & `bw`).
  - Shift `a_sh` and `b_sh` right by 1.
  - Shift `res_sh` right, inserting `d` at the MSB.
  - `cnt` ← `cnt`+1.
- Last bit (`cnt` == `width`−1 at the edge):
  - Load `data_out` ← {`bw_next`, `d`, `res_sh[width-1:1]`}.
  - Assert `done` for the following cycle.
  - Return to IDLE.
- `start` in RUN is ignored. Operands are not re-sampled, and `data_ina`/`data_inb` may change freely while busy.
- `data_out` holds its value until the next completion; it is not cleared when a new operation starts.
- `done` is registered and high for exactly one cycle per completed operation.
- Result arithmetic: `data_out[width]` = 1 exactly when A < B.

## Timing
- Reset (asynchronous, while `rst`=1):
  - state=IDLE.
  - `busy`=0, `done`=0, `data_out`=0.
  - All internal registers 0.
  - Release takes effect at the next edge; the first `start` can be accepted on the first edge after deassertion.
- Latency: for `start` accepted on edge k:
  - `busy`=1 from after edge k through edge k+`width`.
  - `data_out` valid and `done`=1 in the cycle after edge k+`width`.
  - Total: `width` edges after acceptance.
- Throughput: one operation per `width`+1 cycles.
- Back-to-back: `start` may be held high or re-asserted during the `done` cycle (state is IDLE then). The next edge accepts it, `done` drops, and `busy` rises.
- Reset mid-operation: the operation is aborted immediately, no `done` is produced, and `data_out` returns to 0.
- `width`=1: a single RUN cycle; same rules apply.

## Test plan
- Reset, then `width`=4, A=5, B=3, one-cycle `start` → `busy`=1 for 4 cycles, then `done`=1 for 1 cycle with `data_out`=5'b0_0010; `busy`=0 after.
- A=3, B=5 → `data_out`=5'b1_1110. A=0, B=15 → 5'b1_0001. A=15, B=0 → 5'b0_1111. A=B=9 → 5'b0_0000.
- Start A=12, B=4. Pulse `start` with A=1, B=2 at cycle 2 of RUN, and change `data_ina`/`data_inb` mid-operation → single `done`, `data_out`=5'b0_1000; the second request is ignored.
- `start` held high continuously with A=7, B=2 → `done` every 5 cycles, each with `data_out`=5'b0_0101; `done` never high for 2 consecutive cycles.
- Assert `rst` asynchronously mid-RUN (between edges) → `busy`, `done`, `data_out` go to 0 immediately; no `done` after release. A new `start` (A=6, B=6) then completes normally with 0.
- Exhaustive sweep of all 256 operand pairs for `width`=4 against the reference model {A<B, (A−B) mod 16}, plus a random sweep for `width`=8.

Source files
------------

// File: rtl/serial_sub_w_regs.sv
// Bit-serial ripple-borrow subtractor: one full-subtractor cell, LSB first,
// producing a registered {borrow, A-B mod 2^width} with a one-cycle done strobe.
module serial_sub_w_regs #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] data_ina,
    input  logic [width-1:0] data_inb,
    output logic             busy,
    output logic             done,
    output logic [width:0]   data_out,
    output logic             dbg_state
);

    // Handshake: start is accepted on any edge where the block is idle (busy=0);
    // operands are captured on that edge. busy stays high for exactly width
    // cycles, then done pulses for one cycle with data_out updated on the same
    // edge. start seen while busy is ignored; there is no back-pressure.

    localparam int CNT_W = $clog2(width + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(width - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [width-1:0] r_a_sh;
    logic [width-1:0] r_b_sh;
    logic [width-1:0] r_res_sh;
    logic [width-1:0] w_res_next;
    logic             r_bw;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [width:0]   r_data_out;
    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_bw_next;
    logic             w_last;

    assign w_a0      = r_a_sh[0];
    assign w_b0      = r_b_sh[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_bw;
    assign w_bw_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bw);
    assign w_last    = (r_cnt == LAST_CNT);

    // New difference bit enters at the MSB so the LSB lands at bit 0 after width shifts.
    generate
        if (width == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res_sh[width-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_RUN;
            S_RUN:  if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_RUN);
        dbg_state = (r_state == S_RUN);
        done      = r_done;
        data_out  = r_data_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_bw       <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= data_ina;
                        r_b_sh   <= data_inb;
                        r_res_sh <= '0;
                        r_bw     <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_bw     <= w_bw_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_data_out <= {w_bw_next, w_res_next};
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_w_regs.sv
// Directed and swept checks for serial_sub_w_regs at width 4 and width 8.
module tb_serial_sub_w_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic [3:0] ina4 = '0;
    logic [3:0] inb4 = '0;
    logic       busy4, done4, dbg4;
    logic [4:0] out4;
    logic       start8 = 1'b0;
    logic [7:0] ina8 = '0;
    logic [7:0] inb8 = '0;
    logic       busy8, done8, dbg8;
    logic [8:0] out8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_sub_w_regs #(.width(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .data_ina(ina4), .data_inb(inb4),
        .busy(busy4), .done(done4), .data_out(out4), .dbg_state(dbg4)
    );

    serial_sub_w_regs #(.width(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_ina(ina8), .data_inb(inb8),
        .busy(busy8), .done(done8), .data_out(out8), .dbg_state(dbg8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One width-4 operation: drive start for one edge, count busy cycles, check result.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp,
                       input string tag);
        int n_busy;
        int guard;
        @(negedge clk);
        start4 = 1'b1; ina4 = a; inb4 = b;
        @(negedge clk);
        start4 = 1'b0;
        n_busy = 0;
        guard  = 0;
        while (!done4 && guard < 20) begin
            if (busy4) n_busy++;
            @(negedge clk);
            guard++;
        end
        check({tag, "_timeout"}, 32'(guard < 20), 32'd1);
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'd4);
        check({tag, "_busy_at_done"}, 32'(busy4), 32'd0);
        check({tag, "_data"}, 32'(out4), 32'(exp));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done4), 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        int guard;
        @(negedge clk);
        start8 = 1'b1; ina8 = a; inb8 = b;
        @(negedge clk);
        start8 = 1'b0;
        guard = 0;
        while (!done8 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("w8_latency", 32'(guard), 32'd8);
        check("w8_data", 32'(out8), 32'(exp));
    endtask

    initial begin
        int n_done;
        int last_idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] a8;
        logic [7:0] b8;

        #2;
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_data", 32'(out4), 32'd0);
        check("rst_state", 32'(dbg4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op4(4'd5,  4'd3,  5'b0_0010, "a5_b3");
        op4(4'd3,  4'd5,  5'b1_1110, "a3_b5");
        op4(4'd0,  4'd15, 5'b1_0001, "a0_b15");
        op4(4'd15, 4'd0,  5'b0_1111, "a15_b0");
        op4(4'd9,  4'd9,  5'b0_0000, "a9_b9");

        // Second start and operand changes during RUN must be ignored.
        @(negedge clk);
        start4 = 1'b1; ina4 = 4'd12; inb4 = 4'd4;
        @(negedge clk);
        start4 = 1'b0; ina4 = 4'd3; inb4 = 4'd11;
        @(negedge clk);
        start4 = 1'b1; ina4 = 4'd1; inb4 = 4'd2;
        @(negedge clk);
        start4 = 1'b0; ina4 = 4'd14; inb4 = 4'd7;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done4) begin
                n_done++;
                check("ignore_start_data", 32'(out4), 32'b0_1000);
            end
            @(negedge clk);
        end
        check("ignore_start_ndone", 32'(n_done), 32'd1);

        // start held high: done every 5 cycles, never two in a row.
        start4 = 1'b1; ina4 = 4'd7; inb4 = 4'd2;
        n_done   = 0;
        last_idx = -1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done4) begin
                n_done++;
                check("held_data", 32'(out4), 32'b0_0101);
                if (last_idx >= 0) check("held_spacing", 32'(i - last_idx), 32'd5);
                last_idx = i;
            end
        end
        start4 = 1'b0;
        check("held_ndone", 32'(n_done), 32'd5);

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge clk);
        start4 = 1'b1; ina4 = 4'd12; inb4 = 4'd4;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy4), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy4), 32'd0);
        check("async_rst_done", 32'(done4), 32'd0);
        check("async_rst_data", 32'(out4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4) n_done++;
        end
        check("post_rst_no_done", 32'(n_done), 32'd0);
        op4(4'd6, 4'd6, 5'b0_0000, "after_rst_a6_b6");
        op4(4'd10, 4'd2, 5'b0_1000, "after_rst_a10_b2");

        // Exhaustive width-4 sweep against {A<B, (A-B) mod 16}.
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            op4(a, b, {(a < b), 4'(a - b)}, "sweep4");
        end

        // Random width-8 sweep plus corner operands.
        op8(8'd0, 8'd255, {1'b1, 8'd1});
        op8(8'd255, 8'd0, {1'b0, 8'd255});
        op8(8'd128, 8'd128, 9'd0);
        for (int i = 0; i < 40; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            op8(a8, b8, {(a8 < b8), 8'(a8 - b8)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
